// File: rtl/weight_regfile_pkg.sv
// Shared types and default constants for the weight register file.
// The loader state encoding and the default parameter values live here so
// the top and the loader sub-module agree on them.
package weight_regfile_pkg;

    // Bulk-loader states
    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LOAD = 2'd1,
        LD_DONE = 2'd2
    } ld_state_e;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_TAG_W    = 4;
    localparam int DEF_WIN_BASE = 12;
    localparam int DEF_WIN_ROWS = 4;

    // Beat counter width; never narrower than one bit so a single-row
    // window still has a legal counter.
    function automatic int cnt_width(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/weight_regfile_loader.sv
// Window bulk-loader control for weight_regfile.
// Three-process FSM (IDLE -> LOAD -> DONE -> IDLE) plus the beat counter.
// It only decides when a beat is written and at which window row; the
// storage array and the data path stay in the top.
module weight_regfile_loader
    import weight_regfile_pkg::*;
#(
    parameter int WIN_ROWS = DEF_WIN_ROWS,
    localparam int CNT_W   = cnt_width(WIN_ROWS)
) (
    input  logic             clk_i,
    input  logic             reset_n,
    input  logic             ld_start_i,
    input  logic             ld_valid_i,
    output logic             ld_ready_o,
    output logic             ld_busy_o,
    output logic             ld_done_o,
    output logic             win_valid_o,
    output logic             beat_we_o,
    output logic [CNT_W-1:0] beat_idx_o
);

    ld_state_e        state;
    ld_state_e        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             beat;
    logic             last_beat;

    // A beat is accepted whenever valid data arrives while loading.
    assign beat      = (state == LD_LOAD) && ld_valid_i;
    assign last_beat = beat && (cnt == CNT_W'(WIN_ROWS - 1));

    // State register; reset aborts any load in progress.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state <= LD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a start request outside IDLE is ignored.
    always_comb begin
        state_nxt = state;
        case (state)
            LD_IDLE: if (ld_start_i) state_nxt = LD_LOAD;
            LD_LOAD: if (last_beat)  state_nxt = LD_DONE;
            LD_DONE: state_nxt = LD_IDLE;
            default: state_nxt = LD_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        ld_ready_o  = 1'b0;
        ld_busy_o   = 1'b0;
        ld_done_o   = 1'b0;
        win_valid_o = 1'b1;
        case (state)
            LD_LOAD: begin
                ld_ready_o  = 1'b1;
                ld_busy_o   = 1'b1;
                win_valid_o = 1'b0;
            end
            LD_DONE: ld_done_o = 1'b1;
            default: ;
        endcase
    end

    // Beat counter: cleared on start, advanced per accepted beat, held on stall.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if ((state == LD_IDLE) && ld_start_i) begin
            cnt <= '0;
        end else if (beat) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign beat_we_o  = beat;
    assign beat_idx_o = cnt;

endmodule

// File: rtl/weight_regfile.sv
// Tagged register file with a bulk-loadable weight window.
// Two combinational read ports plus a debug port, one core write port, and
// a streaming loader that fills registers WIN_BASE..WIN_BASE+WIN_ROWS-1.
// The window is exported packed on win_o, highest register in the low slice.
// Optional build macro: WEIGHT_REGFILE_BYPASS_EN forwards the same-cycle
// effective write to the read/debug ports; without it reads show the value
// stored before the clock edge.
module weight_regfile
    import weight_regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int TAG_W    = DEF_TAG_W,
    parameter int WIN_BASE = DEF_WIN_BASE,
    parameter int WIN_ROWS = DEF_WIN_ROWS,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                       clk_i,
    input  logic                       reset_n,
    input  logic [ADDR_W-1:0]          rs_addr_i,
    input  logic [ADDR_W-1:0]          rt_addr_i,
    output logic [DATA_W-1:0]          rs_data_o,
    output logic [DATA_W-1:0]          rt_data_o,
    input  logic [ADDR_W-1:0]          rd_addr_i,
    input  logic [DATA_W-1:0]          rd_data_i,
    input  logic [TAG_W-1:0]           rd_tag_i,
    input  logic                       reg_write_i,
    input  logic [ADDR_W-1:0]          dbg_addr_i,
    output logic [DATA_W-1:0]          dbg_data_o,
    output logic [TAG_W-1:0]           dbg_tag_o,
    input  logic                       ld_start_i,
    input  logic                       ld_valid_i,
    input  logic [DATA_W-1:0]          ld_data_i,
    output logic                       ld_ready_o,
    output logic                       ld_busy_o,
    output logic                       ld_done_o,
    output logic [DATA_W*WIN_ROWS-1:0] win_o,
    output logic                       win_valid_o
);

    localparam int CNT_W = cnt_width(WIN_ROWS);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [TAG_W-1:0]  tags [NUM_REGS];

    logic              ld_we;
    logic [CNT_W-1:0]  ld_idx;
    logic [ADDR_W-1:0] ld_addr;
    logic              core_we;

    weight_regfile_loader #(
        .WIN_ROWS (WIN_ROWS)
    ) u_loader (
        .clk_i       (clk_i),
        .reset_n     (reset_n),
        .ld_start_i  (ld_start_i),
        .ld_valid_i  (ld_valid_i),
        .ld_ready_o  (ld_ready_o),
        .ld_busy_o   (ld_busy_o),
        .ld_done_o   (ld_done_o),
        .win_valid_o (win_valid_o),
        .beat_we_o   (ld_we),
        .beat_idx_o  (ld_idx)
    );

    // Loader target row inside the window.
    assign ld_addr = ADDR_W'(WIN_BASE) + ADDR_W'(ld_idx);

    // The loader owns a contended address: the core write is dropped there.
    assign core_we = reg_write_i && !(ld_we && (rd_addr_i == ld_addr));

    // Storage update; core and loader may both write when addresses differ.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
                tags[i] <= '0;
            end
        end else begin
            if (core_we) begin
                regs[rd_addr_i] <= rd_data_i;
                tags[rd_addr_i] <= rd_tag_i;
            end
            if (ld_we) begin
                regs[ld_addr] <= ld_data_i;
                tags[ld_addr] <= '0;
            end
        end
    end

`ifdef WEIGHT_REGFILE_BYPASS_EN
    // Effective same-cycle write seen by the bypass path (loader wins).
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [TAG_W-1:0]  wr_tag;

    assign wr_en   = ld_we || core_we;
    assign wr_addr = ld_we ? ld_addr   : rd_addr_i;
    assign wr_data = ld_we ? ld_data_i : rd_data_i;
    assign wr_tag  = ld_we ? '0        : rd_tag_i;

    // Read ports with forwarding of the write landing this cycle.
    always_comb begin
        rs_data_o  = regs[rs_addr_i];
        rt_data_o  = regs[rt_addr_i];
        dbg_data_o = regs[dbg_addr_i];
        dbg_tag_o  = tags[dbg_addr_i];
        if (wr_en && (rs_addr_i == wr_addr)) rs_data_o = wr_data;
        if (wr_en && (rt_addr_i == wr_addr)) rt_data_o = wr_data;
        if (wr_en && (dbg_addr_i == wr_addr)) begin
            dbg_data_o = wr_data;
            dbg_tag_o  = wr_tag;
        end
    end
`else
    // Read ports straight from storage; writes appear after the clock edge.
    always_comb begin
        rs_data_o  = regs[rs_addr_i];
        rt_data_o  = regs[rt_addr_i];
        dbg_data_o = regs[dbg_addr_i];
        dbg_tag_o  = tags[dbg_addr_i];
    end
`endif

    // Packed window: slice k carries register WIN_BASE+WIN_ROWS-1-k.
    for (genvar k = 0; k < WIN_ROWS; k++) begin : g_win
        assign win_o[DATA_W*(k+1)-1 -: DATA_W] = regs[WIN_BASE + WIN_ROWS - 1 - k];
    end

endmodule

// File: doc/weight_regfile.md
WEIGHT_REGFILE -- requirements
Module: weight_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 32, meaning register count; ADDR_W = clog2(NUM_REGS), derived and not overridable.
REQ-003 SHALL have parameter TAG_W, default 4, meaning per-register tag width.
REQ-004 SHALL have parameter WIN_BASE, default 12, meaning first register of the weight window.
REQ-005 SHALL have parameter WIN_ROWS, default 4, meaning window rows; WIN_BASE+WIN_ROWS <= NUM_REGS.
REQ-006 SHALL have ports, in this order:
- clk_i  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rs_addr_i / rt_addr_i  in  ADDR_W  read addresses.
- rs_data_o / rt_data_o  out  DATA_W  read data.
- rd_addr_i  in  ADDR_W  core write address.
- rd_data_i  in  DATA_W  core write data.
- rd_tag_i  in  TAG_W  core write tag.
- reg_write_i  in  1  core write enable.
- dbg_addr_i  in  ADDR_W  debug address.
- dbg_data_o  out  DATA_W  debug data.
- dbg_tag_o  out  TAG_W  debug tag.
- ld_start_i  in  1  window bulk-load start.
- ld_valid_i  in  1  load beat valid.
- ld_data_i  in  DATA_W  load beat data.
- ld_ready_o  out  1  load beat ready.
- ld_busy_o  out  1  loader active.
- ld_done_o  out  1  one-cycle load-complete pulse.
- win_o  out  DATA_W*WIN_ROWS  packed weight window.
- win_valid_o  out  1  window stable.

Function
REQ-007 SHALL write data and tag to rd_addr_i on the rising clk_i edge when reg_write_i=1.
REQ-008 SHALL drive rs/rt/dbg outputs combinationally from the addressed register and tag.
REQ-009 SHALL pack win_o[DATA_W*(k+1)-1 -: DATA_W] = reg[WIN_BASE+WIN_ROWS-1-k], for k = 0..WIN_ROWS-1.
REQ-010 SHALL implement loader FSM states IDLE, LOAD and DONE.
- IDLE->LOAD on ld_start_i=1, clearing the beat counter.
- LOAD->DONE on the accepted beat where the counter equals WIN_ROWS-1.
- DONE->IDLE unconditionally after one cycle.
REQ-011 SHALL assert ld_ready_o and ld_busy_o only in LOAD, and ld_done_o only in DONE.
REQ-012 SHALL, on each beat with ld_valid_i&ld_ready_o, write ld_data_i to reg[WIN_BASE+cnt] with tag 0, then increment cnt.
REQ-013 SHALL hold cnt and write nothing when ld_valid_i=0 in LOAD (stall).
REQ-014 SHALL ignore ld_start_i outside IDLE.
REQ-015 SHALL give the loader priority when the core and loader write the same address in the same cycle; the core write is dropped.
REQ-016 SHALL perform core writes to other addresses during LOAD normally.
REQ-017 SHALL drive win_valid_o=0 in LOAD and 1 in IDLE and DONE.

Reset
REQ-018 SHALL, while reset_n=0, asynchronously clear all registers and tags to 0, set FSM to IDLE and cnt to 0; outputs: ld_ready_o=0, ld_busy_o=0, ld_done_o=0, win_o=0, win_valid_o=1.
REQ-019 SHALL abort a LOAD in progress on reset, with no partial window retained.

Configuration
REQ-020 SHALL, when WEIGHT_REGFILE_BYPASS_EN is defined, forward the same-cycle effective write (loader or core, per REQ-015) to rs/rt/dbg outputs on address match, tag included.
REQ-021 SHALL, without WEIGHT_REGFILE_BYPASS_EN, show writes on the read ports only after the clock edge.

Structure
REQ-022 SHALL place the loader-state enum and default parameter constants in shared package weight_regfile_pkg.
REQ-023 SHALL implement the loader FSM and counter as sub-module weight_regfile_loader; the storage array stays in the top.

Verification
REQ-024 SHALL cover reset then read: all addresses -> data 0, tag 0, win_valid_o=1, win_o=0.
REQ-025 SHALL cover core write: rd_addr=5, data=0x7FFFE311, tag=0xA -> next cycle rs_addr=5 returns 0x7FFFE311, dbg_tag_o=0xA; same-cycle read returns the new value only with the bypass macro defined.
REQ-026 SHALL cover a bulk load with beats 0x17430 30F, 0x08785B1F, 0x01010101, 0xFFEE1100 and one valid=0 stall -> ld_done_o pulses once, regs 12..15 hold the beats, win_o[31:0]=0xFFEE1100, win_o[127:96]=0x1743030F.
REQ-027 SHALL cover a collision: core write 0xDEADBEEF to reg 12 on the same cycle as loader beat 0x11111111 -> reg 12 holds 0x11111111.
REQ-028 SHALL cover reset mid-load: reset_n=0 after 2 beats -> FSM IDLE, regs 12..13 hold 0; a new ld_start_i loads correctly.
